comparator_bist_driver: RTL and testbench
=========================================

Name: comparator_bist_driver

Overview:
Self-checking stimulus engine for the comparator interface (a_in, b_in -> g_out, l_out, eq_out). It drives every operand pair onto a comparator under test and samples the comparator's three result flags. It checks each result against a golden model, counts mismatches, and reports pass/fail. It is used for on-chip/FPGA bring-up of comparator_1_bit and its wider variants, with no simulator bench required.

Parameters:
WIDTH, 1, operand width driven on a_out/b_out; legal range 1..8.
SETTLE, 1, extra hold cycles per vector before sampling; legal range 0..15.
ERR_W, 2*WIDTH+1, width of the error counter; holds up to 2^(2*WIDTH).

Ports:
clk_in  input  1  single clock, rising edge.
rst_n_in  input  1  asynchronous active-low reset.
start_in  input  1  begin a sweep; sampled in IDLE or DONE only.
a_out  output  WIDTH  operand A to the comparator under test.
b_out  output  WIDTH  operand B to the comparator under test.
g_in  input  1  comparator's A>B flag.
l_in  input  1  comparator's A<B flag.
eq_in  input  1  comparator's A==B flag.
busy_out  output  1  high while the sweep runs.
done_out  output  1  high from sweep end until next start or reset.
pass_out  output  1  done_out AND err_cnt_out==0.
err_cnt_out  output  ERR_W  mismatching vectors in the last sweep.

Behaviour:
- Reset (async, rst_n_in=0): state=IDLE. a_out=0, b_out=0, busy_out=0, done_out=0, pass_out=0, err_cnt_out=0. Vector index and hold counter are cleared.
- Vector index idx is 2*WIDTH bits. a_out=idx[WIDTH-1:0] (toggles fastest), b_out=idx[2*WIDTH-1:WIDTH]. The sweep runs idx 0 to 2^(2*WIDTH)-1 in ascending order.
- FSM states: IDLE, HOLD, CHECK, DONE.
  - IDLE: on start_in=1, go to HOLD. Set idx=0, clear err_cnt_out and the hold counter, set busy_out=1.
  - HOLD: a_out/b_out stay stable. The hold counter counts SETTLE cycles, then the FSM goes to CHECK. With SETTLE=0, HOLD lasts zero cycles and the FSM goes straight to CHECK.
  - CHECK: one cycle, on the same a_out/b_out. At the clock edge ending CHECK, {g_in,l_in,eq_in} is compared to the expected value: exp_g=(a>b), exp_l=(a<b), exp_eq=(a==b), unsigned.
    - Any bit differing counts one error for that vector. Multiple flags high therefore count as one error.
    - If idx is at its maximum, go to DONE. Otherwise increment idx and return to HOLD.
  - DONE: busy_out=0, done_out=1, and pass_out is valid. On start_in=1, clear done_out/pass_out/err_cnt_out and restart exactly as from IDLE.
- Each vector is driven for exactly SETTLE+1 cycles. A full sweep takes 2^(2*WIDTH)*(SETTLE+1) cycles, from the first HOLD cycle until done_out rises.
- start_in is ignored while busy.
- err_cnt_out saturates at its all-ones value and never wraps.
- g_in/l_in/eq_in are assumed synchronous to clk_in; no synchronizer is included.
- A reset asserted mid-sweep aborts immediately and applies the reset values above. No partial result is retained.

Optional Feature:
FIRST_FAIL_CAPTURE_EN:
- Defined: adds outputs fail_valid_out (1), fail_a_out (WIDTH), fail_b_out (WIDTH) and fail_obs_out (3, ordered {g,l,eq}).
  - These latch the first mismatching vector of a sweep and the observed flags.
  - They hold until the next start or reset, which clears all of them to 0.
- Undefined: the ports and capture registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package cmp_pkg:
  - FSM state encoding constants (IDLE/HOLD/CHECK/DONE).
  - Flag bit positions G_BIT=2, L_BIT=1, EQ_BIT=0.
  - Maximum legal WIDTH/SETTLE constants.
- One sub-module: cmp_golden_model. It is purely combinational: given a, b it produces the expected {g,l,eq}, and the bench reuses it.

Test Plan:
1. WIDTH=1, SETTLE=1, correct comparator_1_bit attached, pulse start_in -> vectors (a,b) in order (0,0),(1,0),(0,1),(1,1), each held 2 cycles. done_out rises 8 cycles after HOLD entry. err_cnt_out=0, pass_out=1.
2. WIDTH=1, eq_in tied 1, g_in/l_in tied 0 -> err_cnt_out=2 (vectors idx1, idx2), pass_out=0. With FIRST_FAIL_CAPTURE_EN: fail_a_out=1, fail_b_out=0, fail_obs_out=3'b001.
3. WIDTH=1, g_in and l_in swapped -> err_cnt_out=2, pass_out=0.
4. WIDTH=2, SETTLE=0, correct 2-bit comparator -> 16 vectors, one cycle each, done after 16 cycles, pass_out=1.
5. Assert rst_n_in during idx=2 -> outputs go to 0 asynchronously, state=IDLE. A subsequent start_in runs a full clean sweep.
6. Pulse start_in again at idx=1 while busy -> ignored, sweep completes unchanged. Then start_in in DONE -> err_cnt_out cleared and the sweep restarts.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator BIST driver: FSM state encoding,
// result-flag bit positions and the legal parameter limits.
package cmp_pkg;

  // Sweep controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } cmp_state_e;

  // Position of each comparator flag inside a packed {g,l,eq} triple
  localparam int G_BIT  = 2;
  localparam int L_BIT  = 1;
  localparam int EQ_BIT = 0;
  localparam int FLAG_W = 3;

  // Largest supported operand width and settle delay
  localparam int MAX_WIDTH  = 8;
  localparam int MAX_SETTLE = 15;

  // Width of the per-vector hold counter; covers 0..MAX_SETTLE
  localparam int HOLD_W = 4;

  // Pack three individual flags into a {g,l,eq} vector
  function automatic logic [FLAG_W-1:0] pack_flags(input logic g, input logic l,
                                                   input logic eq);
    logic [FLAG_W-1:0] f;
    f         = '0;
    f[G_BIT]  = g;
    f[L_BIT]  = l;
    f[EQ_BIT] = eq;
    return f;
  endfunction

endpackage

// File: rtl/cmp_golden_model.sv
// Reference comparator: unsigned magnitude compare of a and b, producing the
// expected {g,l,eq} flags. Purely combinational.
module cmp_golden_model
  import cmp_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0]  a_in,
  input  logic [WIDTH-1:0]  b_in,
  output logic [FLAG_W-1:0] exp_flags_out
);

  // Exactly one flag is high for any operand pair
  always_comb begin
    exp_flags_out = pack_flags(a_in > b_in, a_in < b_in, a_in == b_in);
  end

endmodule

// File: rtl/comparator_bist_driver.sv
// Self-checking stimulus engine for a comparator under test. Sweeps every
// {b,a} operand pair in ascending order, holds each pair for SETTLE+1 cycles,
// samples {g,l,eq} on the last cycle and counts mismatching vectors against
// the golden model. Optional build macro FIRST_FAIL_CAPTURE_EN adds ports that
// latch the first failing vector of a sweep and the flags observed on it.
module comparator_bist_driver
  import cmp_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 2*WIDTH+1
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               start_in,
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-1:0]   b_out,
  input  logic               g_in,
  input  logic               l_in,
  input  logic               eq_in,
  output logic               busy_out,
  output logic               done_out,
  output logic               pass_out,
  output logic [ERR_W-1:0]   err_cnt_out
`ifdef FIRST_FAIL_CAPTURE_EN
  ,
  output logic               fail_valid_out,
  output logic [WIDTH-1:0]   fail_a_out,
  output logic [WIDTH-1:0]   fail_b_out,
  output logic [FLAG_W-1:0]  fail_obs_out
`endif
);

  localparam int IDX_W = 2*WIDTH;
  localparam logic [IDX_W-1:0]  IDX_MAX = '1;
  localparam logic [ERR_W-1:0]  ERR_MAX = '1;
  // Last hold-counter value before moving on to CHECK
  localparam logic [HOLD_W-1:0] HOLD_LAST = (SETTLE > 0) ? HOLD_W'(SETTLE - 1) : '0;
  // With no settle time a new vector goes directly to its CHECK cycle
  localparam cmp_state_e VEC_ENTRY = (SETTLE == 0) ? ST_CHECK : ST_HOLD;

  cmp_state_e         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;

  logic [FLAG_W-1:0]  exp_flags;
  logic [FLAG_W-1:0]  obs_flags;
  logic               mismatch;

`ifdef FIRST_FAIL_CAPTURE_EN
  logic               fail_valid_q, fail_valid_d;
  logic [WIDTH-1:0]   fail_a_q, fail_a_d;
  logic [WIDTH-1:0]   fail_b_q, fail_b_d;
  logic [FLAG_W-1:0]  fail_obs_q, fail_obs_d;
`endif

  // Operand A is the low half of the index so it toggles fastest
  assign a_out = idx_q[WIDTH-1:0];
  assign b_out = idx_q[IDX_W-1:WIDTH];

  cmp_golden_model #(
    .WIDTH (WIDTH)
  ) u_golden (
    .a_in          (a_out),
    .b_in          (b_out),
    .exp_flags_out (exp_flags)
  );

  // Any differing flag marks the whole vector as one error
  always_comb begin
    obs_flags = pack_flags(g_in, l_in, eq_in);
    mismatch  = (obs_flags != exp_flags);
  end

  // Next-state and next-output computation for the sweep controller
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
`ifdef FIRST_FAIL_CAPTURE_EN
    fail_valid_d = fail_valid_q;
    fail_a_d     = fail_a_q;
    fail_b_d     = fail_b_q;
    fail_obs_d   = fail_obs_q;
`endif
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_in) begin
          state_d = VEC_ENTRY;
          idx_d   = '0;
          hold_d  = '0;
          err_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
`ifdef FIRST_FAIL_CAPTURE_EN
          fail_valid_d = 1'b0;
          fail_a_d     = '0;
          fail_b_d     = '0;
          fail_obs_d   = '0;
`endif
        end
      end
      ST_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = ST_CHECK;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_CHECK: begin
        if (mismatch && (err_q != ERR_MAX)) begin
          err_d = err_q + ERR_W'(1);
        end
`ifdef FIRST_FAIL_CAPTURE_EN
        if (mismatch && !fail_valid_q) begin
          fail_valid_d = 1'b1;
          fail_a_d     = a_out;
          fail_b_d     = b_out;
          fail_obs_d   = obs_flags;
        end
`endif
        if (idx_q == IDX_MAX) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          state_d = VEC_ENTRY;
          idx_d   = idx_q + IDX_W'(1);
          hold_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Controller state and registered outputs; reset aborts any sweep
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
`ifdef FIRST_FAIL_CAPTURE_EN
      fail_valid_q <= 1'b0;
      fail_a_q     <= '0;
      fail_b_q     <= '0;
      fail_obs_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
`ifdef FIRST_FAIL_CAPTURE_EN
      fail_valid_q <= fail_valid_d;
      fail_a_q     <= fail_a_d;
      fail_b_q     <= fail_b_d;
      fail_obs_q   <= fail_obs_d;
`endif
    end
  end

  assign busy_out    = busy_q;
  assign done_out    = done_q;
  assign pass_out    = pass_q;
  assign err_cnt_out = err_q;

`ifdef FIRST_FAIL_CAPTURE_EN
  assign fail_valid_out = fail_valid_q;
  assign fail_a_out     = fail_a_q;
  assign fail_b_out     = fail_b_q;
  assign fail_obs_out   = fail_obs_q;
`endif

endmodule

// File: tb/tb_comparator_bist_driver.sv
// Bench for comparator_bist_driver: one 1-bit driver (SETTLE=1) with a
// selectable faulty comparator and one 2-bit driver (SETTLE=0). A timeline
// model predicts every output each cycle; directed steps pin key literals.
module tb_comparator_bist_driver;

  localparam int W1 = 1, S1 = 1, W2 = 2, S2 = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start_v [2];
  int   mode_v  [2];   // 0 correct, 1 eq stuck high, 2 g/l swapped

  logic [W1-1:0]      a1, b1;
  logic               g1, l1, eq1, busy1, done1, pass1;
  logic [2*W1:0]      err1;
  logic [2:0]         ref1;
  logic [W2-1:0]      a2, b2;
  logic               g2, l2, eq2, busy2, done2, pass2;
  logic [2*W2:0]      err2;
  logic [2:0]         ref2;
`ifdef FIRST_FAIL_CAPTURE_EN
  logic               fv1, fv2;
  logic [W1-1:0]      fa1, fb1;
  logic [W2-1:0]      fa2, fb2;
  logic [2:0]         fo1, fo2;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Comparator under test: the golden comparator plus an optional fault
  function automatic logic [2:0] cut_out(input int mode, input logic [2:0] r);
    case (mode)
      1:       cut_out = 3'b001;
      2:       cut_out = {r[1], r[2], r[0]};
      default: cut_out = r;
    endcase
  endfunction

  cmp_golden_model #(.WIDTH(W1)) u_cut1 (.a_in(a1), .b_in(b1), .exp_flags_out(ref1));
  cmp_golden_model #(.WIDTH(W2)) u_cut2 (.a_in(a2), .b_in(b2), .exp_flags_out(ref2));
  assign {g1, l1, eq1} = cut_out(mode_v[0], ref1);
  assign {g2, l2, eq2} = cut_out(mode_v[1], ref2);

  comparator_bist_driver #(.WIDTH(W1), .SETTLE(S1)) dut1 (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start_v[0]),
    .a_out(a1), .b_out(b1), .g_in(g1), .l_in(l1), .eq_in(eq1),
    .busy_out(busy1), .done_out(done1), .pass_out(pass1), .err_cnt_out(err1)
`ifdef FIRST_FAIL_CAPTURE_EN
    , .fail_valid_out(fv1), .fail_a_out(fa1), .fail_b_out(fb1), .fail_obs_out(fo1)
`endif
  );

  comparator_bist_driver #(.WIDTH(W2), .SETTLE(S2)) dut2 (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start_v[1]),
    .a_out(a2), .b_out(b2), .g_in(g2), .l_in(l2), .eq_in(eq2),
    .busy_out(busy2), .done_out(done2), .pass_out(pass2), .err_cnt_out(err2)
`ifdef FIRST_FAIL_CAPTURE_EN
    , .fail_valid_out(fv2), .fail_a_out(fa2), .fail_b_out(fb2), .fail_obs_out(fo2)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Flags a comparator with the given fault mode reports for (a,b)
  function automatic logic [2:0] obs_flags(input int mode, input int a, input int b);
    logic g, l, e;
    g = (a > b); l = (a < b); e = (a == b);
    case (mode)
      1:       return 3'b001;
      2:       return {l, g, e};
      default: return {g, l, e};
    endcase
  endfunction

  function automatic bit vec_bad(input int mode, input int a, input int b);
    logic [2:0] want;
    want = {a > b, a < b, a == b};
    return obs_flags(mode, a, b) != want;
  endfunction

  // Errors counted once t cycles have elapsed since the start edge
  function automatic int exp_err(input int w, input int s, input int mode, input int t);
    int n, cnt, lim;
    n = 1 << (2*w); cnt = 0; lim = (1 << (2*w+1)) - 1;
    for (int j = 0; j < n; j++)
      if ((j+1)*(s+1) <= t && vec_bad(mode, j % (1 << w), j >> w)) cnt++;
    return (cnt > lim) ? lim : cnt;
  endfunction

  bit started  [2];
  int t_el     [2];
  int mode_lat [2];

  function automatic int wid(input int i);  return (i == 0) ? W1 : W2; endfunction
  function automatic int stl(input int i);  return (i == 0) ? S1 : S2; endfunction
  function automatic int total(input int i); return (1 << (2*wid(i))) * (stl(i)+1); endfunction

  // Model timeline: a sweep is t cycles old; start honoured only when not busy
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin started[i] = 0; t_el[i] = 0; mode_lat[i] = 0; end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!(started[i] && t_el[i] < total(i)) && start_v[i]) begin
          started[i] = 1; t_el[i] = 0; mode_lat[i] = mode_v[i];
        end else if (started[i] && t_el[i] < total(i)) begin
          t_el[i]++;
        end
      end
    end
  end

  always @(posedge clk) cyc++;

  task automatic check_inst(input int i, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] busy, input logic [31:0] done,
                            input logic [31:0] pass, input logic [31:0] err);
    int w, s, n, k, ee;
    bit e_busy, e_done;
    w = wid(i); s = stl(i); n = 1 << (2*w);
    if (!started[i]) begin
      k = 0; e_busy = 0; e_done = 0; ee = 0;
    end else begin
      k = t_el[i] / (s+1);
      if (k > n-1) k = n-1;
      e_busy = (t_el[i] < total(i));
      e_done = !e_busy;
      ee = exp_err(w, s, mode_lat[i], t_el[i]);
    end
    check($sformatf("u%0d_a", i), a, k % (1 << w));
    check($sformatf("u%0d_b", i), b, k >> w);
    check($sformatf("u%0d_busy", i), busy, 32'(e_busy));
    check($sformatf("u%0d_done", i), done, 32'(e_done));
    check($sformatf("u%0d_pass", i), pass, 32'(e_done && ee == 0));
    check($sformatf("u%0d_err", i), err, ee);
  endtask

`ifdef FIRST_FAIL_CAPTURE_EN
  task automatic check_cap(input int i, input logic [31:0] fv, input logic [31:0] fa,
                           input logic [31:0] fb, input logic [31:0] fo);
    int w, s, jf;
    w = wid(i); s = stl(i); jf = -1;
    if (started[i])
      for (int j = (1 << (2*w)) - 1; j >= 0; j--)
        if ((j+1)*(s+1) <= t_el[i] && vec_bad(mode_lat[i], j % (1 << w), j >> w)) jf = j;
    check($sformatf("u%0d_fail_valid", i), fv, 32'(jf >= 0));
    check($sformatf("u%0d_fail_a", i), fa, (jf >= 0) ? jf % (1 << w) : 0);
    check($sformatf("u%0d_fail_b", i), fb, (jf >= 0) ? jf >> w : 0);
    check($sformatf("u%0d_fail_obs", i), fo,
          (jf >= 0) ? 32'(obs_flags(mode_lat[i], jf % (1 << w), jf >> w)) : 0);
  endtask
`endif

  // Every cycle out of reset, compare both drivers against the model
  always @(negedge clk) begin
    if (rst_n) begin
      check_inst(0, 32'(a1), 32'(b1), 32'(busy1), 32'(done1), 32'(pass1), 32'(err1));
      check_inst(1, 32'(a2), 32'(b2), 32'(busy2), 32'(done2), 32'(pass2), 32'(err2));
`ifdef FIRST_FAIL_CAPTURE_EN
      check_cap(0, 32'(fv1), 32'(fa1), 32'(fb1), 32'(fo1));
      check_cap(1, 32'(fv2), 32'(fa2), 32'(fb2), 32'(fo2));
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic pulse_start(input int i);
    @(posedge clk); #2 start_v[i] = 1'b1;
    @(posedge clk); #2 start_v[i] = 1'b0;
  endtask

  task automatic wait_done(input int i);
    int c;
    c = 0;
    while (!((i == 0) ? done1 : done2) && c < 200) begin @(posedge clk); #1; c++; end
    check($sformatf("u%0d_done_reached", i), 32'((i == 0) ? done1 : done2), 1);
  endtask

  task automatic wait_vec1(input int a, input int b);
    int c;
    c = 0;
    while (!(int'(a1) == a && int'(b1) == b) && c < 50) begin @(posedge clk); #1; c++; end
    check("u0_vec_reached", 32'(int'(a1) == a && int'(b1) == b), 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_a1"}, 32'(a1), 0);      check({tag, "_b1"}, 32'(b1), 0);
    check({tag, "_busy1"}, 32'(busy1), 0); check({tag, "_done1"}, 32'(done1), 0);
    check({tag, "_pass1"}, 32'(pass1), 0); check({tag, "_err1"}, 32'(err1), 0);
    check({tag, "_busy2"}, 32'(busy2), 0); check({tag, "_done2"}, 32'(done2), 0);
    check({tag, "_err2"}, 32'(err2), 0);
  endtask

  initial begin
    int s;
    rst_n = 1'b0; start_v[0] = 1'b0; start_v[1] = 1'b0; mode_v[0] = 0; mode_v[1] = 0;
    #12 check_zero("reset");
    @(posedge clk); #2 rst_n = 1'b1;

    // 1: clean 1-bit sweep, order (0,0),(1,0),(0,1),(1,1), two cycles each
    pulse_start(0);
    for (int c = 0; c < 8; c++) begin
      check($sformatf("t1_vec_c%0d", c), 32'(a1) + 2*32'(b1), c/2);
      check($sformatf("t1_done_c%0d", c), 32'(done1), 0);
      @(posedge clk); #1;
    end
    check("t1_done_at_8", 32'(done1), 1);
    check("t1_err", 32'(err1), 0);
    check("t1_pass", 32'(pass1), 1);
    $display("sweep 1: clean W=1 err=%0d pass=%0d", err1, pass1);

    // 2: eq stuck high -> vectors 1 and 2 fail
    mode_v[0] = 1; pulse_start(0); s = cyc; wait_done(0);
    check("t2_len", cyc - s, 8);
    check("t2_err", 32'(err1), 2);
    check("t2_pass", 32'(pass1), 0);
`ifdef FIRST_FAIL_CAPTURE_EN
    check("t2_fail_a", 32'(fa1), 1); check("t2_fail_b", 32'(fb1), 0);
    check("t2_fail_obs", 32'(fo1), 32'b001);
`endif
    $display("sweep 2: eq stuck err=%0d pass=%0d", err1, pass1);

    // 6: restart from DONE clears result; start while busy is ignored
    mode_v[0] = 0; pulse_start(0); s = cyc;
    check("t6_err_cleared", 32'(err1), 0);
    check("t6_done_cleared", 32'(done1), 0);
    check("t6_busy", 32'(busy1), 1);
    wait_vec1(1, 0);
    start_v[0] = 1'b1; @(posedge clk); #2 start_v[0] = 1'b0;
    wait_done(0);
    check("t6_len", cyc - s, 8);
    check("t6_err", 32'(err1), 0);
    check("t6_pass", 32'(pass1), 1);
    $display("sweep 3: restart+busy start err=%0d pass=%0d", err1, pass1);

    // 3: g/l swapped -> vectors 1 and 2 fail
    mode_v[0] = 2; pulse_start(0); wait_done(0);
    check("t3_err", 32'(err1), 2);
    check("t3_pass", 32'(pass1), 0);
`ifdef FIRST_FAIL_CAPTURE_EN
    check("t3_fail_obs", 32'(fo1), 32'b010);
`endif
    $display("sweep 4: g/l swapped err=%0d pass=%0d", err1, pass1);

    // 4: 2-bit, no settle: 16 vectors, one cycle each
    pulse_start(1); s = cyc; wait_done(1);
    check("t4_len", cyc - s, 16);
    check("t4_err", 32'(err2), 0);
    check("t4_pass", 32'(pass2), 1);
    $display("sweep 5: W=2 err=%0d pass=%0d", err2, pass2);

    // 5: reset mid-sweep at idx 2 clears outputs immediately
    mode_v[0] = 0; pulse_start(0); wait_vec1(0, 1);
    #3 rst_n = 1'b0;
    #1 check_zero("t5_async");
    @(posedge clk); #2 rst_n = 1'b1;
    pulse_start(0); s = cyc; wait_done(0);
    check("t5_len", cyc - s, 8);
    check("t5_err", 32'(err1), 0);
    check("t5_pass", 32'(pass1), 1);
    $display("sweep 6: after mid-sweep reset err=%0d pass=%0d", err1, pass1);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
